axi_lite_apb_rr_bridge: RTL
===========================

# axi_lite_apb_rr_bridge

Parametrised AXI4-Lite slave front-end for the APB master, successor to the single-outstanding write-priority bridge. Per-channel holding registers accept AW, W and AR independently. Round-robin arbitration picks between pending reads and writes. An address window decoder returns DECERR without touching APB, and a wait-state watchdog converts a hung APB transfer into SLVERR.

## Interface
Parameters:
- ADDR_WIDTH, 32: AXI/APB address width.
- DATA_WIDTH, 32: data width; legal values 8/16/32/64; strobe width STRB_W = DATA_WIDTH/8.
- ADDR_LO, 0: lowest decoded address (inclusive).
- ADDR_HI, 32'h0000_FFFF: highest decoded address (inclusive).
- TIMEOUT, 256: maximum S_WAIT cycles before abort; range 2..65535.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR/AWVALID/AWREADY  in/in/out  ADDR_WIDTH/1/1  write address channel.
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/STRB_W/1/1  write data channel.
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1  read address.
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data.
- transfer  out  1  one-cycle APB start pulse.
- read, write  out  1  direction qualifiers, high with transfer.
- apb_waddr, apb_raddr  out  ADDR_WIDTH  held write/read addresses.
- apb_wdata  out  DATA_WIDTH  held write data.
- PSTRB  out  STRB_W  held write strobes.
- apb_rdata  in  DATA_WIDTH  APB read data.
- err_flag  in  1  APB PSLVERR, sampled with apb_done.
- apb_done  in  1  APB completion pulse.
- timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- Holding registers aw_full, w_full, ar_full. Each is set on its VALID&READY handshake and cleared on the corresponding B or R handshake.
- AWREADY = !aw_full, WREADY = !w_full, ARREADY = !ar_full. All three are 0 while ARESET is high. AW and W are accepted in any order or in the same cycle.
- Write pending = aw_full & w_full. Read pending = ar_full.
- Arbitration in S_IDLE: if only one is pending, grant it. If both are pending, grant the direction not granted last. The last_write flag resets to 0, so a write wins the first tie.
- Decode: the address is in range iff ADDR_LO <= addr <= ADDR_HI.
  - Out of range: S_IDLE goes directly to S_WRESP/S_RRESP with resp 2'b11 (DECERR). RDATA = 0. No transfer pulse.
- States:
  - S_IDLE: hold or grant as above.
  - S_REQ: transfer=1 plus read or write = 1 for exactly one cycle, then go to S_WAIT.
  - S_WAIT: wait counter starts at 0 and increments each cycle.
    - apb_done=1: capture RDATA <= apb_rdata (read only). Resp = err_flag ? 2'b10 : 2'b00. Go to the response state.
    - Else if counter == TIMEOUT-1: resp = 2'b10, RDATA = 0, timeout = 1 for that cycle. Go to the response state.
    - apb_done and the timeout condition in the same cycle: apb_done wins, no timeout pulse.
  - S_WRESP: BVALID=1 until BREADY. On handshake, clear aw_full and w_full and go to S_IDLE.
  - S_RRESP: RVALID=1 until RREADY. On handshake, clear ar_full and go to S_IDLE.
- apb_done outside S_WAIT is ignored.
- apb_waddr/apb_wdata/PSTRB/apb_raddr are driven from the holding registers. They are stable from handshake until response completion.
- New AW/W/AR may be accepted into empty holding registers during any state.
- BRESP, RRESP and RDATA hold their values until overwritten by the next response.

## Timing
- Reset (ARESET high at an edge): state=S_IDLE, all full flags 0, last_write=0, counter 0. After that edge, all outputs are 0: BVALID, RVALID, BRESP, RRESP, RDATA, transfer, read, write, timeout, apb_* and PSTRB. Reset mid-transfer abandons it silently.
- Latency: AW&W handshake at edge E0 → S_REQ after E1 (transfer high in cycle E1–E2). apb_done sampled at edge En → BVALID high after En. Same for reads.
- Minimum turnaround: handshake to BVALID/RVALID is 3 edges when apb_done arrives in the first S_WAIT cycle.
- DECERR: handshake at E0 → BVALID/RVALID after E1.
- Back-to-back: the holding register frees at response handshake Em. READY is high after Em. The next grant occurs at Em+1.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path except READY = !full (full is a register).

## Test plan
- Write 0x10, WDATA 0xDEADBEEF, WSTRB 0xF, apb_done 2 cycles after transfer → one transfer+write pulse, apb_waddr=0x10, BRESP=00, BVALID held until BREADY.
- W handshake 3 cycles before AW → no transfer until both are held; then normal write, BRESP=00.
- Read 0x20 with apb_done and err_flag=1, apb_rdata=0x1234 → RDATA=0x1234, RRESP=10.
- Write 0x20000 (out of range) → no transfer, BRESP=11 one cycle after grant.
- Write and read pending together, repeated 4 times → grants alternate W,R,W,R.
- TIMEOUT=4, no apb_done → timeout pulses on the 4th S_WAIT cycle, RRESP=10, RDATA=0. ARESET asserted in S_WAIT → all outputs 0 next cycle and AWREADY/WREADY/ARREADY=1 after reset deasserts.

Source files
------------

// File: rtl/axi_lite_apb_rr_bridge_if.sv
// Bundle of AXI4-Lite slave channels and APB-side control/data for the bridge.
// No logic; pure signal grouping.
// Handshake semantics are defined by the bridge that drives the slave modport.
interface axi_lite_apb_rr_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // AXI4-Lite write address / write data / write response
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_W-1:0]     WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    // AXI4-Lite read address / read data
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    // APB master side
    logic                  transfer;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] apb_waddr;
    logic [ADDR_WIDTH-1:0] apb_raddr;
    logic [DATA_WIDTH-1:0] apb_wdata;
    logic [STRB_W-1:0]     PSTRB;
    logic [DATA_WIDTH-1:0] apb_rdata;
    logic                  err_flag;
    logic                  apb_done;
    logic                  timeout;

    // Bridge view: AXI slave, APB master
    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        output transfer, read, write, apb_waddr, apb_raddr, apb_wdata, PSTRB, timeout,
        input  apb_rdata, err_flag, apb_done
    );

    // Environment view: AXI master, APB completer
    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        input  transfer, read, write, apb_waddr, apb_raddr, apb_wdata, PSTRB, timeout,
        output apb_rdata, err_flag, apb_done
    );
endinterface

// File: rtl/axi_lite_apb_rr_bridge.sv
// AXI4-Lite slave to APB master bridge with per-channel holding regs, round-robin read/write arbitration, address-window DECERR and wait-state watchdog.
// Latency: handshake to transfer pulse 1 cycle; apb_done to B/RVALID 1 cycle; out-of-window handshake to B/RVALID 1 cycle.
// Backpressure: each AXI request channel is ready only while its holding register is empty; responses hold until BREADY/RREADY.
module axi_lite_apb_rr_bridge #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LO    = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HI    = ADDR_WIDTH'(32'h0000_FFFF),
    parameter int                    TIMEOUT    = 256
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    axi_lite_apb_rr_bridge_if.slave   bus
);
    localparam int                    STRB_W   = DATA_WIDTH / 8;
    localparam logic [15:0]           TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_HI - ADDR_LO;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRESP, S_RRESP} state_t;

    state_t                state_q, state_d;
    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q, w_full_d;
    logic                  ar_full_q, ar_full_d;
    logic                  last_write_q, last_write_d;
    logic                  op_write_q, op_write_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  transfer_q, transfer_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic                  timeout_q, timeout_d;

    logic                  aw_rdy, w_rdy, ar_rdy;
    logic                  grant_w;
    logic [ADDR_WIDTH-1:0] addr_off;
    logic [1:0]            apb_resp;

    // READY is purely the inverse of the registered full flags, gated off during reset
    assign aw_rdy = ~aw_full_q & ~ARESET;
    assign w_rdy  = ~w_full_q  & ~ARESET;
    assign ar_rdy = ~ar_full_q & ~ARESET;

    assign bus.AWREADY   = aw_rdy;
    assign bus.WREADY    = w_rdy;
    assign bus.ARREADY   = ar_rdy;
    assign bus.BVALID    = bvalid_q;
    assign bus.BRESP     = bresp_q;
    assign bus.RVALID    = rvalid_q;
    assign bus.RRESP     = rresp_q;
    assign bus.RDATA     = rdata_q;
    assign bus.transfer  = transfer_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.timeout   = timeout_q;
    assign bus.apb_waddr = awaddr_q;
    assign bus.apb_raddr = araddr_q;
    assign bus.apb_wdata = wdata_q;
    assign bus.PSTRB     = wstrb_q;

    // Next-state: channel capture, arbitration, decode, APB wait/watchdog, response handshakes
    always_comb begin
        state_d      = state_q;
        aw_full_d    = aw_full_q;
        w_full_d     = w_full_q;
        ar_full_d    = ar_full_q;
        last_write_d = last_write_q;
        op_write_d   = op_write_q;
        cnt_d        = cnt_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        transfer_d   = 1'b0;
        read_d       = 1'b0;
        write_d      = 1'b0;
        timeout_d    = 1'b0;
        grant_w      = 1'b0;
        addr_off     = '0;
        apb_resp     = bus.err_flag ? 2'b10 : 2'b00;

        // Holding registers fill independently of the FSM
        if (bus.AWVALID && aw_rdy) begin
            aw_full_d = 1'b1;
            awaddr_d  = bus.AWADDR;
        end
        if (bus.WVALID && w_rdy) begin
            w_full_d = 1'b1;
            wdata_d  = bus.WDATA;
            wstrb_d  = bus.WSTRB;
        end
        if (bus.ARVALID && ar_rdy) begin
            ar_full_d = 1'b1;
            araddr_d  = bus.ARADDR;
        end

        case (state_q)
            S_IDLE: begin
                if ((aw_full_q && w_full_q) || ar_full_q) begin
                    // On a tie, the direction not served last wins
                    grant_w      = aw_full_q && w_full_q && (!ar_full_q || !last_write_q);
                    last_write_d = grant_w;
                    op_write_d   = grant_w;
                    // Wrapped offset compare keeps the window test free of constant comparisons
                    addr_off     = (grant_w ? awaddr_q : araddr_q) - ADDR_LO;
                    if (addr_off <= SPAN) begin
                        state_d    = S_REQ;
                        transfer_d = 1'b1;
                        write_d    = grant_w;
                        read_d     = !grant_w;
                    end else if (grant_w) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = 2'b11;
                    end else begin
                        state_d  = S_RRESP;
                        rvalid_d = 1'b1;
                        rresp_d  = 2'b11;
                        rdata_d  = '0;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // Completion beats the watchdog when both land on the same cycle
                if (bus.apb_done) begin
                    if (op_write_q) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = apb_resp;
                    end else begin
                        state_d  = S_RRESP;
                        rvalid_d = 1'b1;
                        rresp_d  = apb_resp;
                        rdata_d  = bus.apb_rdata;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    if (op_write_q) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = 2'b10;
                    end else begin
                        state_d  = S_RRESP;
                        rvalid_d = 1'b1;
                        rresp_d  = 2'b10;
                        rdata_d  = '0;
                    end
                end
            end
            S_WRESP: begin
                if (bus.BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_RRESP: begin
                if (bus.RREADY) begin
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transfer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            ar_full_q    <= 1'b0;
            last_write_q <= 1'b0;
            op_write_q   <= 1'b0;
            cnt_q        <= '0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            rvalid_q     <= 1'b0;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            transfer_q   <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_full_q    <= aw_full_d;
            w_full_q     <= w_full_d;
            ar_full_q    <= ar_full_d;
            last_write_q <= last_write_d;
            op_write_q   <= op_write_d;
            cnt_q        <= cnt_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            transfer_q   <= transfer_d;
            read_q       <= read_d;
            write_q      <= write_d;
            timeout_q    <= timeout_d;
        end
    end
endmodule
